jtdsp16_sio_seq: RTL and testbench



---
 rtl/jtdsp16_sio_seq_pkg.sv | 36 +++
 rtl/jtdsp16_sio_seq_clkgen.sv | 43 ++++
 rtl/jtdsp16_sio_seq.sv | 149 ++++++++++++++
 tb/tb_jtdsp16_sio_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_sio_seq_pkg.sv
// Shared definitions for the DSP16 serial output sequencer.
// Holds default parameter values, the register map, the FSM state
// encodings and the register read-back mux.
package jtdsp16_sio_seq_pkg;

    localparam int          DEF_CLKDIV  = 12;
    localparam int          DEF_WORD    = 16;
    localparam logic [15:0] DEF_SIOC_OK = 16'h02E8;

    // Register map on the CPU side
    localparam logic [1:0] ADDR_SDX  = 2'd0;
    localparam logic [1:0] ADDR_SIOC = 2'd1;
    localparam logic [1:0] ADDR_SRTA = 2'd2;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // SDX is write-only and reads as zero, as does the reserved slot.
    function automatic logic [15:0] sio_rd_mux(
        input logic [1:0]  addr,
        input logic [9:0]  sioc,
        input logic [15:0] srta
    );
        logic [15:0] val;
        val = 16'h0000;
        case (addr)
            ADDR_SIOC: val = {6'b0, sioc};
            ADDR_SRTA: val = srta;
            default:   val = 16'h0000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/jtdsp16_sio_seq_clkgen.sv
// Serial bit clock generator.
// Free-running divider counting 0..CLKDIV-1. The output clock is low for
// the first half of the period and high for the second half; bit_tick marks
// the last clk of each period, which is when the sequencer updates, so data
// changes half a period away from the ock rising edge.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   ock      out serial output clock (registered)
//   bit_tick out one-clk strobe on the last clk of each bit period
module jtdsp16_sio_seq_clkgen #(
    parameter int CLKDIV = 12
) (
    input  logic clk,
    input  logic rst,
    output logic ock,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKDIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign bit_tick = (cnt == CW'(CLKDIV - 1));

    always_comb begin
        cnt_nxt = bit_tick ? '0 : cnt + 1'b1;
    end

    // ock is registered from the next count so it matches cnt>=CLKDIV/2
    // exactly while staying glitch-free on the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ock <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ock <= (cnt_nxt >= CW'(CLKDIV / 2));
        end
    end

endmodule

// File: rtl/jtdsp16_sio_seq.sv
// DSP16 serial output sequencer (Q-Sound usage).
// Owns the SDX output buffer, the shift register and the bit clock. CPU
// words written to SDX are framed with OLD and shifted out MSB first.
//
//   state    | meaning
//   ST_IDLE  | shifter empty, waiting for a pending word at a bit tick
//   ST_LOAD  | one bit period with old=1; closing tick moves obuf to shifter
//   ST_SHIFT | WORD bits shifted out, one per bit period
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cpu_dout, cpu_addr  CPU write data / register select (SDX, SIOC, SRTA)
//   sio_we, sio_rd      one-clk write / read strobes
//   sio_dout            registered read data, valid the clk after sio_rd
//   irq_en              output-empty interrupt enable
//   ock, sio_do, old    serial clock, data and load framing
//   ose, obe            shift register empty / output buffer empty
//   ovr, cfg_err        sticky overrun / unsupported SIOC flags
//   ext_irq             one-clk pulse when obe rises and irq_en=1
// WORD must not exceed 16.
module jtdsp16_sio_seq
    import jtdsp16_sio_seq_pkg::*;
#(
    parameter int          CLKDIV  = DEF_CLKDIV,
    parameter int          WORD    = DEF_WORD,
    parameter logic [15:0] SIOC_OK = DEF_SIOC_OK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_addr,
    input  logic        sio_we,
    input  logic        sio_rd,
    output logic [15:0] sio_dout,
    input  logic        irq_en,
    output logic        ock,
    output logic        sio_do,
    output logic        old,
    output logic        ose,
    output logic        obe,
    output logic        ovr,
    output logic        cfg_err,
    output logic        ext_irq
);

    localparam int BW = $clog2(WORD);

    logic            bit_tick;
    logic [1:0]      state;
    logic [WORD-1:0] obuf;
    logic [WORD-1:0] shreg;
    logic [BW-1:0]   bitcnt;
    logic [9:0]      sioc;
    logic [15:0]     srta;
    logic            sdx_wr;
    logic            xfer;

    jtdsp16_sio_seq_clkgen #(
        .CLKDIV (CLKDIV)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .ock      (ock),
        .bit_tick (bit_tick)
    );

    assign sdx_wr = sio_we && (cpu_addr == ADDR_SDX);
    assign xfer   = bit_tick && (state == ST_LOAD);

    assign old    = (state == ST_LOAD);
    assign sio_do = (state == ST_SHIFT) ? shreg[WORD-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            obuf     <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            obe      <= 1'b1;
            ose      <= 1'b1;
            ovr      <= 1'b0;
            cfg_err  <= 1'b0;
            ext_irq  <= 1'b0;
            sioc     <= SIOC_OK[9:0];
            srta     <= 16'h0000;
            sio_dout <= 16'h0000;
        end else begin
            ext_irq <= 1'b0;

            if (sio_we) begin
                case (cpu_addr)
                    ADDR_SDX: begin
                        obuf <= cpu_dout[WORD-1:0];
                        // A write landing on the transfer tick refills the
                        // buffer the shifter is emptying; not an overrun.
                        if (!obe && !xfer) ovr <= 1'b1;
                    end
                    ADDR_SIOC: begin
                        sioc <= cpu_dout[9:0];
                        if (cpu_dout != SIOC_OK) cfg_err <= 1'b1;
                    end
                    ADDR_SRTA: srta <= cpu_dout;
                    default: ;
                endcase
            end

            // A write in the transfer clk keeps obe low, so no irq edge.
            if (sdx_wr) begin
                obe <= 1'b0;
            end else if (xfer) begin
                obe     <= 1'b1;
                ext_irq <= irq_en;
            end

            if (sio_rd) sio_dout <= sio_rd_mux(cpu_addr, sioc, srta);

            if (bit_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!obe) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        shreg  <= obuf;
                        bitcnt <= '0;
                        ose    <= 1'b0;
                        state  <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BW'(WORD - 1)) begin
                            if (!obe) begin
                                state <= ST_LOAD;
                            end else begin
                                state <= ST_IDLE;
                                ose   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ose   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16_sio_seq.sv
module tb_jtdsp16_sio_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  cpu_addr = '0;
    logic        sio_we = 1'b0;
    logic        sio_rd = 1'b0;
    logic [15:0] sio_dout;
    logic        irq_en = 1'b1;
    logic        ock, sio_do, old, ose, obe, ovr, cfg_err, ext_irq;

    int n_cmp = 0;
    int n_bad = 0;

    jtdsp16_sio_seq dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_dout (cpu_dout),
        .cpu_addr (cpu_addr),
        .sio_we   (sio_we),
        .sio_rd   (sio_rd),
        .sio_dout (sio_dout),
        .irq_en   (irq_en),
        .ock      (ock),
        .sio_do   (sio_do),
        .old      (old),
        .ose      (ose),
        .obe      (obe),
        .ovr      (ovr),
        .cfg_err  (cfg_err),
        .ext_irq  (ext_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic        rd;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_dout;
        logic        exp_cfg;
        logic        exp_obe;
    } reg_vec_t;

    reg_vec_t rv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sio_we = 1'b0;
        sio_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cpu_addr = a;
        cpu_dout = d;
        sio_we   = 1'b1;
        step();
    endtask

    // Waits for a LOAD frame and checks the following word. inj_at selects a
    // same-time SDX write: 1..12 = clk inside LOAD (12 = transfer clk),
    // 13 = first clk of SHIFT, 0 = none. Returns at the middle of the last
    // checked bit.
    task automatic check_word(input string nm, input logic [15:0] exp_bits, input int nbits,
                              input int exp_gap, input logic exp_ose_load,
                              input logic exp_obe, input logic exp_irq,
                              input int inj_at, input logic [15:0] inj_data);
        int nw;
        int n;
        nw = 0;
        while (!old && nw < 40) begin
            step();
            nw++;
        end
        chk({nm, "_old_seen"}, {31'b0, old}, 32'd1);
        if (!old) return;
        if (exp_gap >= 0) chk({nm, "_gap"}, nw, exp_gap);
        n = 1;
        while (1) begin
            if (n == 6) chk({nm, "_ose_load"}, {31'b0, ose}, {31'b0, exp_ose_load});
            if (inj_at == n) begin
                cpu_addr = 2'd0;
                cpu_dout = inj_data;
                sio_we   = 1'b1;
            end
            step();
            if (!old || n >= 30) break;
            n++;
        end
        chk({nm, "_old_len"}, n, 32'd12);
        chk({nm, "_irq"}, {31'b0, ext_irq}, {31'b0, exp_irq});
        chk({nm, "_obe"}, {31'b0, obe}, {31'b0, exp_obe});
        chk({nm, "_ose_shift"}, {31'b0, ose}, 32'd0);
        if (inj_at == 13) begin
            cpu_addr = 2'd0;
            cpu_dout = inj_data;
            sio_we   = 1'b1;
        end
        step();
        chk({nm, "_irq_end"}, {31'b0, ext_irq}, 32'd0);
        chk({nm, "_ock_lo"}, {31'b0, ock}, 32'd0);
        for (int k = 0; k < 5; k++) step();
        chk({nm, "_ock_hi"}, {31'b0, ock}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) for (int k = 0; k < 12; k++) step();
            chk($sformatf("%s_bit%0d", nm, i), {31'b0, sio_do}, {31'b0, exp_bits[15-i]});
        end
    endtask

    initial begin
        int hits;

        // Register vectors: applied one per clk, checked on the next clk
        rv[0]  = '{1'b1, 1'b0, 2'd1, 16'h02E8, 16'h0000, 1'b0, 1'b1};
        rv[1]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h02E8, 1'b0, 1'b1};
        rv[2]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b1};
        rv[3]  = '{1'b1, 1'b0, 2'd2, 16'hBEEF, 16'h0000, 1'b0, 1'b1};
        rv[4]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b1};
        rv[5]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        rv[6]  = '{1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b1};
        rv[7]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b1};
        rv[8]  = '{1'b1, 1'b0, 2'd1, 16'h02E8, 16'h0000, 1'b1, 1'b1};
        rv[9]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h02E8, 1'b1, 1'b1};
        rv[10] = '{1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000, 1'b1, 1'b1};

        // Reset state
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("rst_obe", {31'b0, obe}, 32'd1);
        chk("rst_ose", {31'b0, ose}, 32'd1);
        chk("rst_sio_do", {31'b0, sio_do}, 32'd0);
        chk("rst_old", {31'b0, old}, 32'd0);
        chk("rst_ock", {31'b0, ock}, 32'd0);
        chk("rst_irq", {31'b0, ext_irq}, 32'd0);
        chk("rst_ovr", {31'b0, ovr}, 32'd0);
        chk("rst_cfg", {31'b0, cfg_err}, 32'd0);
        chk("rst_dout", {16'b0, sio_dout}, 32'h0);
        rst = 1'b0;
        step();

        // 1: single word from idle
        wr(2'd0, 16'hA5C3);
        chk("t1_obe_wr", {31'b0, obe}, 32'd0);
        check_word("t1", 16'b1010_0101_1100_0011, 16, -1, 1'b1, 1'b1, 1'b1, 0, 16'h0);
        for (int k = 0; k < 6; k++) step();
        chk("t1_ose_end", {31'b0, ose}, 32'd1);
        chk("t1_sio_do_end", {31'b0, sio_do}, 32'd0);

        // 2: second word written during the first one's shift
        wr(2'd0, 16'h8001);
        check_word("t2a", 16'b1000_0000_0000_0001, 16, -1, 1'b1, 1'b1, 1'b1, 13, 16'h7FFE);
        check_word("t2b", 16'b0111_1111_1111_1110, 16, 6, 1'b0, 1'b1, 1'b1, 0, 16'h0);
        chk("t2_ovr", {31'b0, ovr}, 32'd0);
        for (int k = 0; k < 20; k++) step();

        // 3: two writes before transfer
        wr(2'd0, 16'h1111);
        wr(2'd0, 16'h2222);
        chk("t3_ovr", {31'b0, ovr}, 32'd1);
        check_word("t3", 16'b0010_0010_0010_0010, 16, -1, 1'b1, 1'b1, 1'b1, 0, 16'h0);
        for (int k = 0; k < 20; k++) step();

        // 4: write on the exact transfer clk
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        wr(2'd0, 16'h3C3C);
        check_word("t4a", 16'b0011_1100_0011_1100, 16, -1, 1'b1, 1'b0, 1'b0, 12, 16'hF00F);
        chk("t4_ovr", {31'b0, ovr}, 32'd0);
        check_word("t4b", 16'b1111_0000_0000_1111, 16, 6, 1'b0, 1'b1, 1'b1, 0, 16'h0);
        for (int k = 0; k < 20; k++) step();

        // 6: reset in the middle of bit 7
        wr(2'd0, 16'hFFFF);
        check_word("t6", 16'hFFFF, 8, -1, 1'b1, 1'b1, 1'b1, 0, 16'h0);
        rst = 1'b1;
        step();
        chk("t6_ose", {31'b0, ose}, 32'd1);
        chk("t6_obe", {31'b0, obe}, 32'd1);
        chk("t6_sio_do", {31'b0, sio_do}, 32'd0);
        chk("t6_old", {31'b0, old}, 32'd0);
        rst = 1'b0;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (sio_do || old) hits++;
        end
        chk("t6_no_trailing", hits, 32'd0);

        // 5: register file vectors
        for (int i = 0; i < 11; i++) begin
            cpu_addr = rv[i].addr;
            cpu_dout = rv[i].data;
            sio_we   = rv[i].we;
            sio_rd   = rv[i].rd;
            step();
            chk($sformatf("reg%0d_dout", i), {16'b0, sio_dout}, {16'b0, rv[i].exp_dout});
            chk($sformatf("reg%0d_cfg", i), {31'b0, cfg_err}, {31'b0, rv[i].exp_cfg});
            chk($sformatf("reg%0d_obe", i), {31'b0, obe}, {31'b0, rv[i].exp_obe});
        end

        // Sticky cfg_err clears only on reset, SIOC returns to its default
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cfg_after_rst", {31'b0, cfg_err}, 32'd0);
        cpu_addr = 2'd1;
        sio_rd   = 1'b1;
        step();
        chk("sioc_after_rst", {16'b0, sio_dout}, 32'h02E8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
